// File: rtl/pwm_fader.sv
// Multi-channel PWM brightness generator with per-channel jump or linear fade.
// Duty changes are applied only at PWM period boundaries so pulses are never torn.
module pwm_fader #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CH_BITS      = 2,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                Load,
    input  logic [CH_BITS-1:0]  Chan,
    input  logic [WIDTH-1:0]    Target,
    input  logic                Mode,
    output logic [CHANNELS-1:0] Pwm,
    output logic                Busy,
    output logic                PeriodEnd
);

    localparam int unsigned      STEP_BITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(STEP_PERIODS - 1);

    logic [WIDTH-1:0]     cnt;
    logic [STEP_BITS-1:0] step_cnt;
    logic [WIDTH-1:0]     target [CHANNELS];
    logic [WIDTH-1:0]     active [CHANNELS];
    logic [CHANNELS-1:0]  mode;

    logic                 boundary;
    logic                 step_boundary;
    logic [WIDTH-1:0]     active_nxt [CHANNELS];
    logic [CHANNELS-1:0]  load_sel;
    logic [CHANNELS-1:0]  pwm_nxt;
    logic [CHANNELS-1:0]  busy_vec;

    assign boundary      = (cnt == CNT_MAX);
    assign step_boundary = boundary && (step_cnt == STEP_LAST);

    // Channel decode; selects at or above CHANNELS match nothing and are dropped.
    always_comb begin
        load_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_sel[i] = Load && (Chan == CH_BITS'(i));
        end
    end

    // Boundary update of the applied duty from the pre-load target/mode.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            active_nxt[i] = active[i];
            if (boundary) begin
                if (!mode[i]) begin
                    active_nxt[i] = target[i];
                end else if (step_boundary) begin
                    if (active[i] < target[i]) begin
                        active_nxt[i] = active[i] + WIDTH'(1);
                    end else if (active[i] > target[i]) begin
                        active_nxt[i] = active[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pwm_nxt  = '0;
        busy_vec = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i]  = (cnt < active[i]);
            busy_vec[i] = (active[i] != target[i]);
        end
    end

    assign Busy = |busy_vec;

    // Period/step counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cnt       <= '0;
            step_cnt  <= '0;
            Pwm       <= '0;
            PeriodEnd <= 1'b0;
        end else begin
            cnt       <= cnt + WIDTH'(1);
            Pwm       <= pwm_nxt;
            PeriodEnd <= boundary;
            if (boundary) begin
                step_cnt <= step_boundary ? '0 : step_cnt + STEP_BITS'(1);
            end
        end
    end

    // Per-channel target, mode and applied duty.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            mode <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                active[i] <= active_nxt[i];
                if (load_sel[i]) begin
                    target[i] <= Target;
                    mode[i]   <= Mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboarded bench for pwm_fader: cycle model plus directed high-time checks.
module tb_pwm_fader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHN   = 3;
    localparam int unsigned PER   = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [1:0]       chan = '0;
    logic [WIDTH-1:0] target = '0;
    logic             mode = 1'b0;
    logic [CHN-1:0]   pwm;
    logic             busy;
    logic             period_end;

    int checks = 0;
    int errors = 0;
    int hi [CHN][40];

    logic [4:0] sb [$];

    pwm_fader #(
        .WIDTH(WIDTH), .CHANNELS(CHN), .CH_BITS(2), .STEP_PERIODS(4)
    ) dut (
        .CLOCK_50(clk), .Reset(rst), .Load(load), .Chan(chan), .Target(target),
        .Mode(mode), .Pwm(pwm), .Busy(busy), .PeriodEnd(period_end)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: samples inputs on each edge and queues the expected outputs.
    initial begin
        int  m_cnt, m_step;
        int  m_act [CHN];
        int  m_tgt [CHN];
        bit  m_mode [CHN];
        bit  started;
        logic [CHN-1:0] e_pwm;
        logic e_busy, e_pe;
        started = 0;
        m_cnt = 0; m_step = 0;
        for (int i = 0; i < CHN; i++) begin m_act[i] = 0; m_tgt[i] = 0; m_mode[i] = 0; end
        forever begin
            @(posedge clk);
            if (rst) begin
                started = 1;
                m_cnt = 0; m_step = 0;
                for (int i = 0; i < CHN; i++) begin m_act[i] = 0; m_tgt[i] = 0; m_mode[i] = 0; end
                sb.push_back(5'b0);
            end else if (started) begin
                for (int i = 0; i < CHN; i++) e_pwm[i] = (m_cnt < m_act[i]);
                e_pe = (m_cnt == PER - 1);
                if (m_cnt == PER - 1) begin
                    for (int i = 0; i < CHN; i++) begin
                        if (!m_mode[i]) m_act[i] = m_tgt[i];
                        else if (m_step == 3) begin
                            if (m_act[i] < m_tgt[i]) m_act[i]++;
                            else if (m_act[i] > m_tgt[i]) m_act[i]--;
                        end
                    end
                    m_step = (m_step + 1) % 4;
                end
                if (load && int'(chan) < CHN) begin
                    m_tgt[chan] = int'(target);
                    m_mode[chan] = mode;
                end
                m_cnt = (m_cnt + 1) % PER;
                e_busy = 1'b0;
                for (int i = 0; i < CHN; i++) if (m_act[i] != m_tgt[i]) e_busy = 1'b1;
                sb.push_back({e_pwm, e_busy, e_pe});
            end
        end
    end

    // Compare queued expectations against the DUT away from the active edge.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cycle", {pwm, busy, period_end}, e);
            end
        end
    end

    task automatic do_load(input logic [1:0] c, input logic [WIDTH-1:0] t, input logic m);
        @(negedge clk); #1;
        load = 1'b1; chan = c; target = t; mode = m;
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_pe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 2 * PER);
        if (!period_end) check("pe_timeout", period_end, 1);
    endtask

    // Count high cycles per channel over n consecutive periods, ending on a PeriodEnd cycle.
    task automatic measure(input int n, input bit need_pe);
        if (need_pe) wait_pe();
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < CHN; c++) hi[c][p] = 0;
            for (int k = 0; k < PER; k++) begin
                @(negedge clk);
                for (int c = 0; c < CHN; c++) if (pwm[c]) hi[c][p]++;
            end
        end
    endtask

    function automatic int count_val(input int c, input int n, input int v);
        int r = 0;
        for (int p = 0; p < n; p++) if (hi[c][p] == v) r++;
        return r;
    endfunction

    initial begin
        int pe_cnt, first_pe, found, tries, mx;

        // 1: reset, then idle
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_pwm", pwm, 0);
        #1 rst = 1'b0;
        pe_cnt = 0; first_pe = -1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (period_end) begin
                pe_cnt++;
                if (first_pe < 0) first_pe = i;
            end
        end
        check("idle_pe_count", pe_cnt, 2);
        check("idle_first_pe", first_pe, 256);
        check("idle_pwm", pwm, 0);
        check("idle_busy", busy, 0);

        // 2: jump load on channel 1
        do_load(2'd1, 8'd64, 1'b0);
        check("jump_busy_rise", busy, 1);
        measure(2, 1);
        check("jump_hi_p0", hi[1][0], 64);
        check("jump_hi_p1", hi[1][1], 64);
        check("jump_busy_fall", busy, 0);

        // 3: fade channel 0 from 0 up to 3
        do_load(2'd0, 8'd3, 1'b1);
        check("fade_busy_rise", busy, 1);
        measure(20, 1);
        check("fade_cnt1", count_val(0, 20, 1), 4);
        check("fade_cnt2", count_val(0, 20, 2), 4);
        check("fade_final", hi[0][19], 3);
        check("fade_ch1_hold", hi[1][19], 64);
        check("fade_busy_fall", busy, 0);

        // 4: channel 2 ramp to 10, redirect to 2 once active first reaches 5
        do_load(2'd2, 8'd10, 1'b1);
        found = 0; tries = 0;
        wait_pe();
        while (!found && tries < 40) begin
            measure(1, 0);
            tries++;
            if (hi[2][0] == 5) found = 1;
        end
        check("ramp_reach5", found, 1);
        do_load(2'd2, 8'd2, 1'b1);
        measure(16, 1);
        mx = 0;
        for (int p = 0; p < 16; p++) if (hi[2][p] > mx) mx = hi[2][p];
        check("rev_max", mx, 5);
        check("rev_cnt5", count_val(2, 16, 5), 2);
        check("rev_cnt4", count_val(2, 16, 4), 4);
        check("rev_cnt3", count_val(2, 16, 3), 4);
        check("rev_final", hi[2][15], 2);
        check("rev_ch0_hold", count_val(0, 16, 3), 16);
        check("rev_ch1_hold", count_val(1, 16, 64), 16);

        // 5: load on the exact boundary clock
        wait_pe();
        repeat (PER - 1) @(negedge clk);
        #1 load = 1'b1; chan = 2'd0; target = 8'd255; mode = 1'b0;
        @(negedge clk);
        check("bnd_align", period_end, 1);
        #1 load = 1'b0;
        measure(2, 0);
        check("bnd_old_duty", hi[0][0], 3);
        check("bnd_new_duty", hi[0][1], 255);
        check("bnd_ch2_hold", hi[2][1], 2);

        // 6: out-of-range channel ignored, then reset mid-fade
        do_load(2'd3, 8'd200, 1'b0);
        check("oor_busy", busy, 0);
        measure(2, 1);
        check("oor_ch0", hi[0][1], 255);
        check("oor_ch1", hi[1][1], 64);
        check("oor_ch2", hi[2][1], 2);
        do_load(2'd1, 8'd0, 1'b1);
        check("midfade_busy", busy, 1);
        repeat (300) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_busy", busy, 0);
        check("rst_pe", period_end, 0);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
